mem_write_first: RTL and testbench
==================================

# mem_write_first

Single-port synchronous RAM with write-first (read-during-write returns new data) semantics and a registered read port. It is the per-lane storage primitive of the byte-addressable data memory: four 8-bit instances, each with its own write enable, form one 32-bit word with byte strobes. The storage array must be reachable by hierarchical reference so simulation can preload each lane with `$readmemh`.

## Interface
Parameters:
- DATA_WIDTH, default 32: word width in bits; instantiated as 8 for byte lanes.
- ADDRESS_WIDTH, default 4: address width; depth = 2**ADDRESS_WIDTH words.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- we  input  1  write enable for the addressed word.
- addr  input  ADDRESS_WIDTH  word address, used for both read and write.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  registered read data.

## Operation
- Storage: array named `mem`, indices 0 .. 2**ADDRESS_WIDTH-1, each DATA_WIDTH bits.
- The array must be a plain `reg` array at module top level so `$readmemh(file, inst.mem)` works.
- The array has no reset and no initial assignment in RTL. Contents are X until preloaded or written.
- Rising edge with rst=1:
  - dout <= 0.
  - Writes are suppressed: `mem` is unchanged even if we=1.
- Rising edge with rst=0, we=1:
  - mem[addr] <= din.
  - dout <= din (write-first: new data, not old contents).
- Rising edge with rst=0, we=0:
  - dout <= mem[addr]. No array change.
- Priority: rst > we > read.
- Every cycle is a read cycle: dout updates on every edge, so it always reflects the addr presented at the previous edge.
- No address range checking is needed: every addr value is a valid index.
- Width rule: din is stored verbatim, with no extension or truncation.
- dout must not change between clock edges; it is driven only by its register.

## Timing
- Read latency: 1 cycle.
  - addr sampled at edge N.
  - Data valid on dout after edge N, held until edge N+1.
- Write latency: 1 cycle.
  - A read of the same address at edge N+1 returns the written value.
  - The write cycle itself already shows din on dout after edge N.
- Back-to-back writes to different addresses: each completes in its own cycle. dout tracks din each cycle.
- Write immediately followed by a read of the same address: returns the new data, with no hazard bubble.
- Reset mid-operation:
  - Takes effect at the next edge; dout = 0 from that edge.
  - Previously written contents are retained.
  - The first read after rst deasserts returns the pre-reset contents.
- dout value before the first edge or reset: undefined, and not relied upon.

## Test plan
1. Reset: rst=1 for 2 cycles with we=1, addr=3, din=0xA5 → dout=0 after each edge. mem[3] unchanged: a later read of addr 3 returns the preloaded or prior value, not 0xA5.
2. Write-first: rst=0, we=1, addr=5, din=0x3C → dout=0x3C after the same edge. Next cycle we=0, addr=5 → dout=0x3C.
3. Preload and read: `$readmemh` loads mem[0..15] = 0x00..0x0F. Sweep addr 0..15 with we=0 → dout equals addr, one cycle after each address is presented. Covers the wrap at addr 15.
4. Back-to-back writes then readback: write 0x11, 0x22, 0x33 to addr 0, 1, 15 on consecutive cycles, then read 0, 1, 15 → 0x11, 0x22, 0x33.
5. Overwrite: write 0xAA then 0x55 to addr 7 on consecutive edges → dout 0xAA then 0x55; a subsequent read gives 0x55.
6. Byte-lane composition: four DATA_WIDTH=8 instances share addr, with we driven by strobe bits. Write word 0xDEADBEEF with strobes 1111, then write 0x000000FF with strobes 0001 → readback 0xDEADBEFF.

Source files
------------

// File: rtl/mem_write_first.sv
// mem_write_first: single-port RAM, write-first, registered read, no array reset
module mem_write_first #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout
);
  reg [DATA_WIDTH-1:0] mem [0:2**ADDRESS_WIDTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (we) begin
      mem[addr] <= din;
      dout <= din;
    end else begin
      dout <= mem[addr];
    end
  end
endmodule

// File: tb/tb_mem_write_first.sv
// tb_mem_write_first: random and directed checks against an array reference model
module tb_mem_write_first;
  logic clk = 0;
  logic rst = 1;
  logic we = 0;
  logic [3:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [3:0] lane_we = '0;
  logic [31:0] lane_din = '0;
  logic [31:0] lane_dout;
  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [16];
  bit known [16];

  always #5 clk = ~clk;

  mem_write_first #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .din(din), .dout(dout)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_write_first #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) lane (
      .clk(clk), .rst(rst), .we(lane_we[g]), .addr(addr),
      .din(lane_din[8*g+:8]), .dout(lane_dout[8*g+:8])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock edge on the main instance; the model decides what dout must show
  task automatic cyc(input string tag, input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] exp;
    bit exp_ok;
    rst = r; we = w; addr = a; din = d;
    @(posedge clk);
    #1;
    exp_ok = 1;
    if (r) exp = 0;
    else if (w) begin
      ref_mem[a] = d;
      known[a] = 1;
      exp = d;
    end else begin
      exp = ref_mem[a];
      exp_ok = known[a];
    end
    if (exp_ok) check(tag, dout, exp);
  endtask

  task automatic lane_cyc(input logic [3:0] strb, input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
    rst = 0; we = 0; lane_we = strb; addr = a; lane_din = d;
    @(posedge clk);
    #1;
    check(tag, lane_dout, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) known[i] = 0;
    cyc("first_write3", 0, 1, 3, 32'h5A);
    cyc("reset_a", 1, 1, 3, 32'hA5);
    cyc("reset_b", 1, 1, 3, 32'hA5);
    cyc("read3_after_reset", 0, 0, 3, 32'h0);
    cyc("write_first5", 0, 1, 5, 32'h3C);
    cyc("read5", 0, 0, 5, 32'h0);
    for (int i = 0; i < 16; i++) cyc("preload", 0, 1, 4'(i), 32'(i));
    for (int i = 0; i < 16; i++) cyc("sweep", 0, 0, 4'(i), 32'hFFFF_FFFF);
    cyc("b2b_w0", 0, 1, 0, 32'h11);
    cyc("b2b_w1", 0, 1, 1, 32'h22);
    cyc("b2b_w15", 0, 1, 15, 32'h33);
    cyc("b2b_r0", 0, 0, 0, 32'h0);
    cyc("b2b_r1", 0, 0, 1, 32'h0);
    cyc("b2b_r15", 0, 0, 15, 32'h0);
    cyc("ovr_aa", 0, 1, 7, 32'hAA);
    cyc("ovr_55", 0, 1, 7, 32'h55);
    cyc("ovr_read", 0, 0, 7, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc("random", ($urandom_range(15) == 0), $urandom_range(1), 4'($urandom_range(15)), $urandom);
    cyc("rst_mid", 1, 0, 2, 32'h0);
    cyc("read_after_rst", 0, 0, 2, 32'h0);
    lane_cyc(4'b1111, 9, 32'hDEADBEEF, 32'hDEADBEEF, "lane_full");
    lane_cyc(4'b0001, 9, 32'h000000FF, 32'hDEADBEFF, "lane_strb");
    lane_cyc(4'b0000, 9, 32'h12345678, 32'hDEADBEFF, "lane_read");
    lane_cyc(4'b1010, 9, 32'h11223344, 32'h11AD33FF, "lane_mixed");
    lane_cyc(4'b0000, 9, 32'h0, 32'h11AD33FF, "lane_read2");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
